// File: rtl/id_stage_if.sv
// id_stage_if: groups the IF-side inputs, write-back port, hazard controls
// and the ID/EX register contents of the decode stage into one bundle.
// The slave modport is the decode stage; the master modport is whoever
// drives it (the surrounding pipeline or a testbench).
interface id_stage_if;

    // Fetch side
    logic [31:0] i_instr;
    logic [31:0] i_pc_plus4;

    // Branch/jump squash resolved in EX
    logic        i_flush;

    // Write-back port into the register file
    logic        i_wb_write;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;

    // Hazard controls back to IF
    logic        o_pc_write;
    logic        o_stall;

    // ID/EX pipeline register contents
    logic        o_idex_valid;
    logic [31:0] o_idex_pc_plus4;
    logic [31:0] o_idex_rs_data;
    logic [31:0] o_idex_rt_data;
    logic [31:0] o_idex_imm;
    logic [5:0]  o_idex_opcode;
    logic [5:0]  o_idex_funct;
    logic [4:0]  o_idex_rs;
    logic [4:0]  o_idex_rt;
    logic [4:0]  o_idex_rd;

    modport slave (
        input  i_instr, i_pc_plus4, i_flush,
        input  i_wb_write, i_wb_addr, i_wb_data,
        output o_pc_write, o_stall,
        output o_idex_valid, o_idex_pc_plus4, o_idex_rs_data, o_idex_rt_data,
        output o_idex_imm, o_idex_opcode, o_idex_funct,
        output o_idex_rs, o_idex_rt, o_idex_rd
    );

    modport master (
        output i_instr, i_pc_plus4, i_flush,
        output i_wb_write, i_wb_addr, i_wb_data,
        input  o_pc_write, o_stall,
        input  o_idex_valid, o_idex_pc_plus4, o_idex_rs_data, o_idex_rt_data,
        input  o_idex_imm, o_idex_opcode, o_idex_funct,
        input  o_idex_rs, o_idex_rt, o_idex_rd
    );

endinterface

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the five-stage pipeline.
// Holds the IF/ID register, the 32x32 register file with a write-first
// bypass on the write-back port, load-use hazard detection (one-cycle stall
// of PC and IF/ID with a bubble into ID/EX) and the ID/EX register.
module id_stage (
    input  logic        i_clock,
    input  logic        i_reset,
    id_stage_if.slave   bus
);

    localparam logic [5:0] OPC_LW = 6'h23;

    // IF/ID pipeline register
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic        r_ifid_valid;

    // Register file storage
    logic [31:0] r_regs [0:31];

    // ID/EX pipeline register
    logic        r_idex_valid;
    logic [31:0] r_idex_pc_plus4;
    logic [31:0] r_idex_rs_data;
    logic [31:0] r_idex_rt_data;
    logic [31:0] r_idex_imm;
    logic [5:0]  r_idex_opcode;
    logic [5:0]  r_idex_funct;
    logic [4:0]  r_idex_rs;
    logic [4:0]  r_idex_rt;
    logic [4:0]  r_idex_rd;

    // Decode-side wires
    logic [4:0]  w_ifid_rs;
    logic [4:0]  w_ifid_rt;
    logic [4:0]  w_ifid_rd;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    logic [31:0] w_imm;
    logic        w_stall;
    logic        w_pc_write;
    logic        w_rf_we;

    assign w_ifid_rs = r_ifid_instr[25:21];
    assign w_ifid_rt = r_ifid_instr[20:16];
    assign w_ifid_rd = r_ifid_instr[15:11];
    assign w_imm     = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};

    // r0 is hard-wired, so writes aimed at it are dropped here
    assign w_rf_we = bus.i_wb_write & (bus.i_wb_addr != 5'd0);

    // Load-use hazard: a valid load in EX whose destination (rt) is read by
    // the valid instruction in ID. Both rs and rt are compared regardless of
    // opcode; a bubble in EX never matches because its valid bit is clear.
    always_comb begin
        w_stall = 1'b0;
        if (r_ifid_valid && r_idex_valid && (r_idex_opcode == OPC_LW) &&
            (r_idex_rt != 5'd0) &&
            ((r_idex_rt == w_ifid_rs) || (r_idex_rt == w_ifid_rt))) begin
            w_stall = 1'b1;
        end else begin
            w_stall = 1'b0;
        end
    end

    // A flush must always let the PC take the branch target, even mid-stall
    always_comb begin
        w_pc_write = 1'b1;
        if (bus.i_flush) begin
            w_pc_write = 1'b1;
        end else begin
            w_pc_write = ~w_stall;
        end
    end

    // Register file read ports with r0 forced to zero and write-first bypass
    always_comb begin
        w_rs_data = 32'd0;
        w_rt_data = 32'd0;
        if (w_ifid_rs == 5'd0) begin
            w_rs_data = 32'd0;
        end else if (w_rf_we && (bus.i_wb_addr == w_ifid_rs)) begin
            w_rs_data = bus.i_wb_data;
        end else begin
            w_rs_data = r_regs[w_ifid_rs];
        end
        if (w_ifid_rt == 5'd0) begin
            w_rt_data = 32'd0;
        end else if (w_rf_we && (bus.i_wb_addr == w_ifid_rt)) begin
            w_rt_data = bus.i_wb_data;
        end else begin
            w_rt_data = r_regs[w_ifid_rt];
        end
    end

    // Register file write port; reset clears every entry
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (w_rf_we) begin
            r_regs[bus.i_wb_addr] <= bus.i_wb_data;
        end else begin
            r_regs[bus.i_wb_addr] <= r_regs[bus.i_wb_addr];
        end
    end

    // IF/ID register: flush squashes, stall holds, otherwise capture fetch.
    // On a flush the PC field is left as is; it is meaningless while invalid.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ifid_instr <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_ifid_valid <= 1'b0;
        end else if (bus.i_flush) begin
            r_ifid_instr <= 32'd0;
            r_ifid_pc    <= r_ifid_pc;
            r_ifid_valid <= 1'b0;
        end else if (w_stall) begin
            r_ifid_instr <= r_ifid_instr;
            r_ifid_pc    <= r_ifid_pc;
            r_ifid_valid <= r_ifid_valid;
        end else begin
            r_ifid_instr <= bus.i_instr;
            r_ifid_pc    <= bus.i_pc_plus4;
            r_ifid_valid <= 1'b1;
        end
    end

    // ID/EX register: reset, flush or stall insert an all-zero bubble
    always_ff @(posedge i_clock) begin
        if (i_reset || bus.i_flush || w_stall) begin
            r_idex_valid    <= 1'b0;
            r_idex_pc_plus4 <= 32'd0;
            r_idex_rs_data  <= 32'd0;
            r_idex_rt_data  <= 32'd0;
            r_idex_imm      <= 32'd0;
            r_idex_opcode   <= 6'd0;
            r_idex_funct    <= 6'd0;
            r_idex_rs       <= 5'd0;
            r_idex_rt       <= 5'd0;
            r_idex_rd       <= 5'd0;
        end else begin
            r_idex_valid    <= r_ifid_valid;
            r_idex_pc_plus4 <= r_ifid_pc;
            r_idex_rs_data  <= w_rs_data;
            r_idex_rt_data  <= w_rt_data;
            r_idex_imm      <= w_imm;
            r_idex_opcode   <= r_ifid_instr[31:26];
            r_idex_funct    <= r_ifid_instr[5:0];
            r_idex_rs       <= w_ifid_rs;
            r_idex_rt       <= w_ifid_rt;
            r_idex_rd       <= w_ifid_rd;
        end
    end

    assign bus.o_stall         = w_stall;
    assign bus.o_pc_write      = w_pc_write;
    assign bus.o_idex_valid    = r_idex_valid;
    assign bus.o_idex_pc_plus4 = r_idex_pc_plus4;
    assign bus.o_idex_rs_data  = r_idex_rs_data;
    assign bus.o_idex_rt_data  = r_idex_rt_data;
    assign bus.o_idex_imm      = r_idex_imm;
    assign bus.o_idex_opcode   = r_idex_opcode;
    assign bus.o_idex_funct    = r_idex_funct;
    assign bus.o_idex_rs       = r_idex_rs;
    assign bus.o_idex_rt       = r_idex_rt;
    assign bus.o_idex_rd       = r_idex_rd;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios plus randomized traffic for id_stage,
// compared each cycle against a behavioural pipeline model.
module tb_id_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    id_stage_if bus ();

    id_stage u_dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state: the architectural registers, the instruction
    // word sitting in ID and the instruction word (plus operands) in EX.
    logic [31:0] m_regs [32];
    logic [31:0] m_id_instr;
    logic [31:0] m_id_pc;
    bit          m_id_valid;
    logic [31:0] m_ex_instr;
    logic [31:0] m_ex_pc;
    logic [31:0] m_ex_a;
    logic [31:0] m_ex_b;
    bit          m_ex_valid;
    bit          m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx, input bit wbw,
                                           input logic [4:0] wba, input logic [31:0] wbd);
        if (idx == 5'd0) return 32'd0;
        if (wbw && (wba == idx)) return wbd;
        return m_regs[idx];
    endfunction

    // A load in EX whose destination register is a source of the ID instruction
    function automatic bit m_hazard();
        logic [4:0] dest;
        dest = m_ex_instr[20:16];
        return m_id_valid && m_ex_valid && (m_ex_instr[31:26] == 6'h23) && (dest != 5'd0) &&
               ((dest == m_id_instr[25:21]) || (dest == m_id_instr[20:16]));
    endfunction

    // One clock: drive inputs, compare DUT to model, advance model, take the edge
    task automatic step(input bit r, input logic [31:0] instr, input logic [31:0] pc,
                        input bit fl, input bit wbw, input logic [4:0] wba, input logic [31:0] wbd);
        bit          hz;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sext;
        rst            = r;
        bus.i_instr    = instr;
        bus.i_pc_plus4 = pc;
        bus.i_flush    = fl;
        bus.i_wb_write = wbw;
        bus.i_wb_addr  = wba;
        bus.i_wb_data  = wbd;
        #3;
        if (m_known) begin
            hz   = m_hazard();
            sext = {{16{m_ex_instr[15]}}, m_ex_instr[15:0]};
            check_eq("stall",      {31'd0, bus.o_stall},        {31'd0, hz});
            check_eq("pc_write",   {31'd0, bus.o_pc_write},     {31'd0, (!hz) || fl});
            check_eq("idex_valid", {31'd0, bus.o_idex_valid},   {31'd0, m_ex_valid});
            check_eq("opcode",     {26'd0, bus.o_idex_opcode},  {26'd0, m_ex_instr[31:26]});
            check_eq("funct",      {26'd0, bus.o_idex_funct},   {26'd0, m_ex_instr[5:0]});
            check_eq("rs",         {27'd0, bus.o_idex_rs},      {27'd0, m_ex_instr[25:21]});
            check_eq("rt",         {27'd0, bus.o_idex_rt},      {27'd0, m_ex_instr[20:16]});
            check_eq("rd",         {27'd0, bus.o_idex_rd},      {27'd0, m_ex_instr[15:11]});
            check_eq("imm",        bus.o_idex_imm,              sext);
            check_eq("rs_data",    bus.o_idex_rs_data,          m_ex_a);
            check_eq("rt_data",    bus.o_idex_rt_data,          m_ex_b);
            if (m_ex_valid) check_eq("pc_plus4", bus.o_idex_pc_plus4, m_ex_pc);
        end
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_id_instr = 32'd0; m_id_pc = 32'd0; m_id_valid = 1'b0;
            m_ex_instr = 32'd0; m_ex_pc = 32'd0; m_ex_a = 32'd0; m_ex_b = 32'd0; m_ex_valid = 1'b0;
            m_known = 1'b1;
        end else begin
            hz = m_hazard();
            a  = m_read(m_id_instr[25:21], wbw, wba, wbd);
            b  = m_read(m_id_instr[20:16], wbw, wba, wbd);
            if (fl || hz) begin
                m_ex_instr = 32'd0; m_ex_pc = 32'd0; m_ex_a = 32'd0; m_ex_b = 32'd0; m_ex_valid = 1'b0;
            end else begin
                m_ex_instr = m_id_instr; m_ex_pc = m_id_pc; m_ex_a = a; m_ex_b = b; m_ex_valid = m_id_valid;
            end
            if (fl) begin
                m_id_instr = 32'd0; m_id_valid = 1'b0;
            end else if (!hz) begin
                m_id_instr = instr; m_id_pc = pc; m_id_valid = 1'b1;
            end
            if (wbw && (wba != 5'd0)) m_regs[wba] = wbd;
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] LW_8_9    = 32'h8D280004;
    localparam logic [31:0] ADD_10_8_9  = 32'h01095020;
    localparam logic [31:0] ADD_10_11_12 = 32'h016C5020;

    initial begin
        logic [4:0]  idx;
        logic [5:0]  opc;
        logic [31:0] rin;
        bit          rr, rf, rw;
        logic [4:0]  ra;

        // Reset for two cycles
        step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("rst_stall",    {31'd0, bus.o_stall},      32'd0);
        check_eq("rst_pc_write", {31'd0, bus.o_pc_write},   32'd1);
        check_eq("rst_valid",    {31'd0, bus.o_idex_valid}, 32'd0);
        check_eq("rst_rs_data",  bus.o_idex_rs_data,        32'd0);

        // Read r1..r31 after reset through both ports
        for (int i = 1; i < 32; i++) begin
            idx = i[4:0];
            step(1'b0, {6'd0, idx, idx, 5'd1, 5'd0, 6'h20}, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 5'd0, 32'd0);
        end

        // Passthrough: r8=5, r9=7, then add $10,$8,$9
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd8, 32'd5);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'd9, 32'd7);
        step(1'b0, ADD_10_8_9, 32'h4, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'd0, 32'h8, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("pt_rs_data", bus.o_idex_rs_data, 32'd5);
        check_eq("pt_rt_data", bus.o_idex_rt_data, 32'd7);
        check_eq("pt_rd",      {27'd0, bus.o_idex_rd},    32'd10);
        check_eq("pt_funct",   {26'd0, bus.o_idex_funct}, 32'h20);
        check_eq("pt_pc",      bus.o_idex_pc_plus4,       32'h4);
        check_eq("pt_valid",   {31'd0, bus.o_idex_valid}, 32'd1);

        // Load-use: lw $8 followed by a reader of $8
        step(1'b0, LW_8_9,     32'h8,  1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, ADD_10_8_9, 32'hC,  1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("lu_stall",    {31'd0, bus.o_stall},    32'd1);
        check_eq("lu_pc_write", {31'd0, bus.o_pc_write}, 32'd0);
        step(1'b0, 32'd0, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("lu_stall_once", {31'd0, bus.o_stall},      32'd0);
        check_eq("lu_bubble",     {31'd0, bus.o_idex_valid}, 32'd0);
        step(1'b0, 32'd0, 32'h10, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("lu_add_valid", {31'd0, bus.o_idex_valid}, 32'd1);
        check_eq("lu_add_rd",    {27'd0, bus.o_idex_rd},    32'd10);
        check_eq("lu_add_pc",    bus.o_idex_pc_plus4,       32'hC);

        // Control: lw $8 followed by an independent add
        step(1'b0, LW_8_9,       32'h14, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, ADD_10_11_12, 32'h18, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("ctl_stall",    {31'd0, bus.o_stall},    32'd0);
        check_eq("ctl_pc_write", {31'd0, bus.o_pc_write}, 32'd1);
        step(1'b0, 32'd0, 32'h1C, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("ctl_valid", {31'd0, bus.o_idex_valid}, 32'd1);
        check_eq("ctl_pc",    bus.o_idex_pc_plus4,       32'h18);

        // Bypass: write r3 while an instruction in ID reads rs=3
        step(1'b0, 32'h00600020, 32'h20, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'd0,        32'h24, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);
        check_eq("byp_rs_data", bus.o_idex_rs_data, 32'hDEADBEEF);

        // r0 ignores writes
        step(1'b0, 32'd0,        32'h28, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
        step(1'b0, 32'h00001020, 32'h2C, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'd0,        32'h30, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("r0_rs_data", bus.o_idex_rs_data, 32'd0);
        check_eq("r0_rt_data", bus.o_idex_rt_data, 32'd0);
        check_eq("r0_valid",   {31'd0, bus.o_idex_valid}, 32'd1);

        // Flush with valid instructions in IF/ID and ID/EX
        step(1'b0, ADD_10_8_9,   32'h40, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, ADD_10_11_12, 32'h44, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, 32'd0,        32'h48, 1'b1, 1'b0, 5'd0, 32'd0);
        check_eq("fl_idex_valid", {31'd0, bus.o_idex_valid}, 32'd0);
        step(1'b0, 32'd0, 32'h4C, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("fl_ifid_squashed", {31'd0, bus.o_idex_valid}, 32'd0);

        // Flush during a load-use stall
        step(1'b0, LW_8_9,     32'h60, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, ADD_10_8_9, 32'h64, 1'b0, 1'b0, 5'd0, 32'd0);
        bus.i_flush = 1'b1;
        #1;
        check_eq("fs_stall",    {31'd0, bus.o_stall},    32'd1);
        check_eq("fs_pc_write", {31'd0, bus.o_pc_write}, 32'd1);
        step(1'b0, 32'd0, 32'h68, 1'b1, 1'b0, 5'd0, 32'd0);
        check_eq("fs_valid", {31'd0, bus.o_idex_valid}, 32'd0);
        check_eq("fs_stall_after", {31'd0, bus.o_stall}, 32'd0);

        // Reset in the middle of a stall
        step(1'b0, LW_8_9,     32'h70, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b0, ADD_10_8_9, 32'h74, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("rs_stall_before", {31'd0, bus.o_stall}, 32'd1);
        step(1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        check_eq("rs_stall_after", {31'd0, bus.o_stall},      32'd0);
        check_eq("rs_valid_after", {31'd0, bus.o_idex_valid}, 32'd0);

        // Randomized traffic biased toward loads and a few registers
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0:       opc = 6'h23;
                1:       opc = 6'h00;
                2:       opc = 6'h2B;
                default: opc = 6'($urandom_range(0, 63));
            endcase
            rin = {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            rr  = ($urandom_range(0, 199) == 0);
            rf  = ($urandom_range(0, 15) == 0);
            rw  = ($urandom_range(0, 1) == 1);
            ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            step(rr, rin, $urandom, rf, rw, ra, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
